// File: rtl/gen_wbq_if.sv
// Writeback-queue bus: ALU and load-unit requests, register-file write port, forwarding lookups.
interface gen_wbq_if;
    logic        alu_v;
    logic [4:0]  alu_rd_n;
    logic [31:0] alu_wd;
    logic        alu_rdy;
    logic        mem_v;
    logic [4:0]  mem_rd_n;
    logic [31:0] mem_wd;
    logic        mem_rdy;
    logic        rd;
    logic [4:0]  rd_n;
    logic [31:0] wd;
    logic [4:0]  rs1_n;
    logic [4:0]  rs2_n;
    logic        fwd1_v;
    logic [31:0] fwd1_d;
    logic        fwd2_v;
    logic [31:0] fwd2_d;
    logic [2:0]  cnt;

    modport master (
        output alu_v, alu_rd_n, alu_wd, mem_v, mem_rd_n, mem_wd, rs1_n, rs2_n,
        input  alu_rdy, mem_rdy, rd, rd_n, wd, fwd1_v, fwd1_d, fwd2_v, fwd2_d, cnt
    );

    modport slave (
        input  alu_v, alu_rd_n, alu_wd, mem_v, mem_rd_n, mem_wd, rs1_n, rs2_n,
        output alu_rdy, mem_rdy, rd, rd_n, wd, fwd1_v, fwd1_d, fwd2_v, fwd2_d, cnt
    );
endinterface

// File: rtl/gen_wbq.sv
// 4-entry register writeback queue, mem priority over alu, head drains every cycle.
// Forwarding from stored entries is enabled by defining GEN_WBQ_FWD_EN.
module gen_wbq (
    input logic      m_clock,
    input logic      p_reset,
    gen_wbq_if.slave bus
);
    logic [4:0]  ent_n_q [4];
    logic [31:0] ent_d_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        full;
    logic        mem_rdy, alu_rdy;
    logic        push_mem, push_alu, push, pop;
    logic [4:0]  wr_n;
    logic [31:0] wr_d;
    logic        rd_v;

    always_comb begin
        full     = (cnt_q == 3'd4);
        mem_rdy  = ~p_reset & bus.mem_v & ~full;
        alu_rdy  = ~p_reset & bus.alu_v & ~bus.mem_v & ~full;
        // Writes to x0 are acknowledged but never stored.
        push_mem = mem_rdy & (bus.mem_rd_n != 5'd0);
        push_alu = alu_rdy & (bus.alu_rd_n != 5'd0);
        push     = push_mem | push_alu;
        wr_n     = push_mem ? bus.mem_rd_n : bus.alu_rd_n;
        wr_d     = push_mem ? bus.mem_wd : bus.alu_wd;
        pop      = (cnt_q != 3'd0);
        rd_v     = ~p_reset & pop;

        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; occupancy is tracked solely by cnt_q.
    always_ff @(posedge m_clock) begin
        if (!p_reset && push) begin
            ent_n_q[wr_ptr_q] <= wr_n;
            ent_d_q[wr_ptr_q] <= wr_d;
        end
    end

    assign bus.mem_rdy = mem_rdy;
    assign bus.alu_rdy = alu_rdy;
    assign bus.rd      = rd_v;
    assign bus.rd_n    = rd_v ? ent_n_q[rd_ptr_q] : 5'd0;
    assign bus.wd      = rd_v ? ent_d_q[rd_ptr_q] : 32'd0;
    assign bus.cnt     = cnt_q;

`ifdef GEN_WBQ_FWD_EN
    logic        fwd1_v, fwd2_v;
    logic [31:0] fwd1_d, fwd2_d;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [1:0] idx;
        fwd1_v = 1'b0;
        fwd1_d = 32'd0;
        fwd2_v = 1'b0;
        fwd2_d = 32'd0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rd_ptr_q + 2'(i);
            if ((3'(i) < cnt_q) && (bus.rs1_n != 5'd0) && (ent_n_q[idx] == bus.rs1_n)) begin
                fwd1_v = 1'b1;
                fwd1_d = ent_d_q[idx];
            end
            if ((3'(i) < cnt_q) && (bus.rs2_n != 5'd0) && (ent_n_q[idx] == bus.rs2_n)) begin
                fwd2_v = 1'b1;
                fwd2_d = ent_d_q[idx];
            end
        end
    end

    assign bus.fwd1_v = fwd1_v;
    assign bus.fwd1_d = fwd1_d;
    assign bus.fwd2_v = fwd2_v;
    assign bus.fwd2_d = fwd2_d;
`else
    assign bus.fwd1_v = 1'b0;
    assign bus.fwd1_d = 32'd0;
    assign bus.fwd2_v = 1'b0;
    assign bus.fwd2_d = 32'd0;
`endif
endmodule

// File: tb/tb_gen_wbq.sv
// Randomized bench for gen_wbq against a queue-based reference model.
module tb_gen_wbq;
    logic m_clock = 1'b0;
    logic p_reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    gen_wbq_if bus ();

    gen_wbq u_dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    always #5 m_clock = ~m_clock;

    typedef struct {
        logic [4:0]  n;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] rs);
`ifdef GEN_WBQ_FWD_EN
        if (rs != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].n == rs) return {1'b1, mq[i].d};
            end
        end
`endif
        return 33'd0;
    endfunction

    task automatic cycle(input logic av, input logic [4:0] an, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mn, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2, input logic rst);
        logic        e_full, e_mrdy, e_ardy, e_rd;
        logic [32:0] f1, f2;
        ent_t        hd;
        @(negedge m_clock);
        bus.alu_v = av; bus.alu_rd_n = an; bus.alu_wd = ad;
        bus.mem_v = mv; bus.mem_rd_n = mn; bus.mem_wd = md;
        bus.rs1_n = r1; bus.rs2_n = r2;
        p_reset   = rst;
        #1;
        e_full = (mq.size() == 4);
        e_mrdy = !rst && mv && !e_full;
        e_ardy = !rst && av && !mv && !e_full;
        e_rd   = !rst && (mq.size() != 0);
        hd.n   = 5'd0;
        hd.d   = 32'd0;
        if (e_rd) hd = mq[0];
        f1 = model_fwd(r1);
        f2 = model_fwd(r2);
        check_eq("mem_rdy", 32'(bus.mem_rdy), 32'(e_mrdy));
        check_eq("alu_rdy", 32'(bus.alu_rdy), 32'(e_ardy));
        check_eq("rd", 32'(bus.rd), 32'(e_rd));
        check_eq("rd_n", 32'(bus.rd_n), 32'(hd.n));
        check_eq("wd", bus.wd, hd.d);
        check_eq("cnt", 32'(bus.cnt), mq.size());
        check_eq("fwd1_v", 32'(bus.fwd1_v), 32'(f1[32]));
        check_eq("fwd1_d", bus.fwd1_d, f1[31:0]);
        check_eq("fwd2_v", 32'(bus.fwd2_v), 32'(f2[32]));
        check_eq("fwd2_d", bus.fwd2_d, f2[31:0]);
        @(posedge m_clock);
        if (rst) begin
            mq.delete();
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (e_mrdy && mn != 5'd0) mq.push_back('{n: mn, d: md});
            else if (e_ardy && an != 5'd0) mq.push_back('{n: an, d: ad});
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2, 1'b0);
    endtask

    initial begin
        bus.alu_v = 1'b0; bus.alu_rd_n = '0; bus.alu_wd = '0;
        bus.mem_v = 1'b0; bus.mem_rd_n = '0; bus.mem_wd = '0;
        bus.rs1_n = '0;   bus.rs2_n = '0;
        repeat (2) @(posedge m_clock);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check_eq("reset_cnt", 32'(bus.cnt), 32'd0);

        // Single write then drain.
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        // Priority: mem wins, alu held.
        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd4, 5'd3, 1'b0);
        cycle(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'd0, 5'd4, 5'd3, 1'b0);
        idle(5'd3, 5'd4);
        idle(5'd3, 5'd4);

        // Stream of mem writes to rd 1..6.
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 16), 5'(i), 5'(i - 1), 1'b0);
        end
        idle(5'd6, 5'd0);
        idle(5'd0, 5'd0);

        // Same destination back-to-back.
        cycle(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0);
        cycle(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);

        // x0 write is dropped.
        cycle(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        idle(5'd0, 5'd0);

        // Reset pulse during activity.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h100, 5'd9, 5'd10, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h101, 5'd10, 5'd11, 1'b1);
        idle(5'd11, 5'd10);

        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
